// File: rtl/instr_fetch_queue_pkg.sv
// Shared sizing constants and helpers for the instruction fetch queue.
package instr_fetch_queue_pkg;
  localparam int IFQ_ADDR_W        = 32;
  localparam int IFQ_INSTR_W       = 32;
  localparam int FETCH_QUEUE_DEPTH = 4;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/instr_fetch_queue_if.sv
// PC, instruction-memory and decode handshakes seen by the fetch queue.
interface instr_fetch_queue_if
  import instr_fetch_queue_pkg::*;
#(
  parameter int ADDR_W  = IFQ_ADDR_W,
  parameter int INSTR_W = IFQ_INSTR_W
);
  logic [ADDR_W-1:0]  pc_in;
  logic               pc_hold;
  logic               flush;
  logic               imem_req_valid;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_req_ready;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic               dec_valid;
  logic [INSTR_W-1:0] dec_instr;
  logic [ADDR_W-1:0]  dec_pc;
  logic               dec_ready;

  modport master (
    input  pc_in, flush, imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready,
    output pc_hold, imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc
  );

  modport slave (
    output pc_in, flush, imem_req_ready, imem_resp_valid, imem_resp_data, dec_ready,
    input  pc_hold, imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc
  );
endinterface

// File: rtl/instr_fetch_queue_fetch_entry_buf.sv
// Entry storage: per-slot PC, instruction and filled flag with separate
// allocate, fill and read ports.
module fetch_entry_buf
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH   = FETCH_QUEUE_DEPTH,
  parameter int ADDR_W  = IFQ_ADDR_W,
  parameter int INSTR_W = IFQ_INSTR_W,
  parameter int IW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               alloc_en,
  input  logic [IW-1:0]      alloc_idx,
  input  logic [ADDR_W-1:0]  alloc_pc,
  input  logic               fill_en,
  input  logic [IW-1:0]      fill_idx,
  input  logic [INSTR_W-1:0] fill_instr,
  input  logic [IW-1:0]      rd_idx,
  output logic [ADDR_W-1:0]  rd_pc,
  output logic [INSTR_W-1:0] rd_instr,
  output logic               rd_filled
);
  logic [DEPTH-1:0][ADDR_W-1:0]  pc_q, pc_d;
  logic [DEPTH-1:0][INSTR_W-1:0] instr_q, instr_d;
  logic [DEPTH-1:0]              filled_q, filled_d;

  // Alloc and fill never target the same slot: fill trails tail by < DEPTH.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    filled_d = filled_q;
    if (alloc_en) begin
      pc_d[alloc_idx]     = alloc_pc;
      filled_d[alloc_idx] = 1'b0;
    end
    if (fill_en) begin
      instr_d[fill_idx]  = fill_instr;
      filled_d[fill_idx] = 1'b1;
    end
    if (clear) filled_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) filled_q <= '0;
    else     filled_q <= filled_d;
    pc_q    <= pc_d;
    instr_q <= instr_d;
  end

  assign rd_pc     = pc_q[rd_idx];
  assign rd_instr  = instr_q[rd_idx];
  assign rd_filled = filled_q[rd_idx];
endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues PC requests, tracks outstanding responses and delivers
// returned instructions to decode in order; flush discards everything in flight.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int ADDR_W  = IFQ_ADDR_W,
  parameter int INSTR_W = IFQ_INSTR_W,
  parameter int DEPTH   = FETCH_QUEUE_DEPTH
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_queue_if.master bus
);
  localparam int PW = ptr_w(DEPTH);
  localparam int IW = PW - 1;
  localparam logic [PW:0] CAP = (PW+1)'(DEPTH);

  logic [PW-1:0] head_q, head_d, fill_q, fill_d, tail_q, tail_d, disc_q, disc_d;
  logic [PW-1:0] count, outst;
  logic [PW:0]   used;
  logic          req_ok, accept, resp_take, resp_drop, resp_sub, head_filled, pop;

  assign count = tail_q - head_q;
  assign outst = tail_q - fill_q;
  // Capacity counts stale in-flight responses: they still need a landing cycle.
  assign used  = {1'b0, count} + {1'b0, disc_q};

  assign req_ok    = !rst && !bus.flush && (used < CAP);
  assign accept    = req_ok && bus.imem_req_ready;
  assign resp_drop = bus.imem_resp_valid && (disc_q != '0);
  assign resp_take = bus.imem_resp_valid && (disc_q == '0) && (outst != '0) && !bus.flush;
  assign resp_sub  = bus.imem_resp_valid && ((disc_q != '0) || (outst != '0));
  assign pop       = bus.dec_valid && bus.dec_ready && !bus.flush;

  assign bus.imem_req_valid = req_ok;
  assign bus.imem_req_addr  = bus.pc_in;
  assign bus.pc_hold        = !accept;
  assign bus.dec_valid      = (count != '0) && head_filled;

  always_comb begin
    head_d = head_q;
    fill_d = fill_q;
    tail_d = tail_q;
    disc_d = disc_q;
    if (bus.flush) begin
      head_d = '0;
      fill_d = '0;
      tail_d = '0;
      disc_d = disc_q + outst - PW'(resp_sub);
    end else begin
      if (accept)    tail_d = tail_q + PW'(1);
      if (resp_take) fill_d = fill_q + PW'(1);
      if (pop)       head_d = head_q + PW'(1);
      if (resp_drop) disc_d = disc_q - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      disc_q <= '0;
    end else begin
      head_q <= head_d;
      fill_q <= fill_d;
      tail_q <= tail_d;
      disc_q <= disc_d;
    end
  end

  fetch_entry_buf #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .IW(IW)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .clear      (bus.flush),
    .alloc_en   (accept),
    .alloc_idx  (tail_q[IW-1:0]),
    .alloc_pc   (bus.pc_in),
    .fill_en    (resp_take),
    .fill_idx   (fill_q[IW-1:0]),
    .fill_instr (bus.imem_resp_data),
    .rd_idx     (head_q[IW-1:0]),
    .rd_pc      (bus.dec_pc),
    .rd_instr   (bus.dec_instr),
    .rd_filled  (head_filled)
  );
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench: request-level reference model plus an in-order scoreboard
// of expected decode deliveries checked by an independent monitor.
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;
  localparam int DEPTH = FETCH_QUEUE_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_queue_if bus();
  instr_fetch_queue dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic [31:0] pc; bit ret; } sb_t;
  typedef struct { logic [31:0] addr; int gen; int due; } mem_t;

  sb_t  sb[$];
  mem_t pend[$];
  int n_checks = 0, n_err = 0, cyc = 0, gen = 0, last_due = 0;
  int p_rdy = 100, p_dec = 100, p_flush = 0, kmax = 1;
  logic [31:0] pc = 32'h0;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One clock of stimulus; the model advances exactly as the coming edge should.
  task automatic step(input bit do_rst);
    bit fl, rv, rdy, exp_rv, acc, exp_dv, done;
    int stale, k, d;
    mem_t m;
    @(posedge clk); #1;
    cyc++;
    fl  = !do_rst && ($urandom_range(99) < p_flush);
    rdy = ($urandom_range(99) < p_rdy);
    rv  = !do_rst && (pend.size() > 0) && (pend[0].due <= cyc);
    rst = do_rst;
    bus.flush           = fl;
    bus.imem_req_ready  = rdy;
    bus.dec_ready       = !do_rst && ($urandom_range(99) < p_dec);
    bus.pc_in           = pc;
    bus.imem_resp_valid = rv;
    bus.imem_resp_data  = rv ? imem(pend[0].addr) : $urandom;
    #1;
    stale = 0;
    foreach (pend[i]) if (pend[i].gen != gen) stale++;
    exp_rv = !do_rst && !fl && ((sb.size() + stale) < DEPTH);
    acc    = exp_rv && rdy;
    exp_dv = (sb.size() > 0) && sb[0].ret;
    chk("req_valid", bus.imem_req_valid, exp_rv);
    chk("pc_hold", bus.pc_hold, !acc);
    if (exp_rv) chk("req_addr", bus.imem_req_addr, pc);
    chk("dec_valid", bus.dec_valid, exp_dv);
    if (do_rst) begin
      sb.delete(); pend.delete(); pc = 32'h0; last_due = 0;
      return;
    end
    if (rv) begin
      m = pend.pop_front();
      done = 0;
      if (m.gen == gen && !fl)
        foreach (sb[i]) if (!done && !sb[i].ret) begin sb[i].ret = 1; done = 1; end
    end
    if (acc) begin
      k = $urandom_range(kmax, 1);
      d = cyc + k;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back('{pc, gen, d});
      sb.push_back('{pc, 1'b0});
    end
    if (fl) begin
      sb.delete();
      gen++;
      pc = $urandom & 32'h0003_FFFC;
    end else if (acc) pc = pc + 32'd4;
  endtask

  // Memory must never answer with nothing outstanding.
  always @(posedge clk)
    if (!rst && bus.imem_resp_valid)
      assert (pend.size() > 0) else $error("response with nothing outstanding");

  // Decode-side monitor: every pop must match the oldest expected instruction.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.dec_valid && bus.dec_ready && !bus.flush) begin
        if (sb.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL dec_pop cycle %0d: got pc %0h expected no delivery", cyc, bus.dec_pc);
        end else begin
          e = sb.pop_front();
          chk("dec_pc", bus.dec_pc, e.pc);
          chk("dec_instr", bus.dec_instr, imem(e.pc));
        end
      end
    end
  end

  initial begin
    bus.pc_in = '0; bus.flush = 0; bus.imem_req_ready = 0;
    bus.imem_resp_valid = 0; bus.imem_resp_data = '0; bus.dec_ready = 0;
    repeat (3) step(1);
    p_rdy = 100; p_dec = 100; p_flush = 0; kmax = 1;
    repeat (40) step(0);
    p_dec = 0;
    repeat (10) step(0);
    p_dec = 100;
    repeat (20) step(0);
    p_rdy = 60; p_dec = 70; kmax = 4;
    repeat (300) step(0);
    p_flush = 8;
    repeat (600) step(0);
    p_rdy = 90; p_dec = 80; p_flush = 3;
    repeat (6) begin
      repeat ($urandom_range(30, 10)) step(0);
      step(1);
    end
    p_flush = 0; p_rdy = 100; p_dec = 100; kmax = 1;
    repeat (100) step(0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
